devil_snoop_engine: RTL and testbench

//  Parametrised ACE snoop-channel responder: N address/snoop match windows, each with its own mode, CR delay, CRRESP and arm state.

---
 rtl/devil_snoop_engine_pkg.sv | 35 +++
 rtl/devil_snoop_engine_win_match.sv | 75 +++++++
 rtl/devil_snoop_engine.sv | 187 ++++++++++++++++++
 tb/tb_devil_snoop_engine.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/devil_snoop_engine_pkg.sv
// Shared types and constants for the devil snoop-channel responder.
// Holds the FSM state encoding, window modes, CRRESP bit positions and ACSNOOP codes.
package devil_snoop_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MATCH = 3'd1,
    ST_DELAY = 3'd2,
    ST_CR    = 3'd3,
    ST_CD    = 3'd4
  } state_e;

  typedef enum logic {
    WIN_OSH = 1'b0,
    WIN_CON = 1'b1
  } win_mode_e;

  localparam int CRRESP_DT = 0;
  localparam int CRRESP_ERR = 1;
  localparam int CRRESP_PASS_DIRTY = 2;
  localparam int CRRESP_IS_SHARED = 3;
  localparam int CRRESP_WAS_UNIQUE = 4;

  localparam logic [3:0] ACSNOOP_READ_ONCE        = 4'b0000;
  localparam logic [3:0] ACSNOOP_READ_SHARED      = 4'b0001;
  localparam logic [3:0] ACSNOOP_READ_CLEAN       = 4'b0010;
  localparam logic [3:0] ACSNOOP_READ_NSD         = 4'b0011;
  localparam logic [3:0] ACSNOOP_READ_UNIQUE      = 4'b0111;
  localparam logic [3:0] ACSNOOP_CLEAN_SHARED     = 4'b1000;
  localparam logic [3:0] ACSNOOP_CLEAN_INVALID    = 4'b1001;
  localparam logic [3:0] ACSNOOP_MAKE_INVALID     = 4'b1101;
  localparam logic [3:0] ACSNOOP_DVM_COMPLETE     = 4'b1110;
  localparam logic [3:0] ACSNOOP_DVM_MESSAGE      = 4'b1111;

endpackage

// File: rtl/devil_snoop_engine_win_match.sv
// One snoop match window: snoop/address filter, one-shot arm/done flags and a saturating hit counter.
// The match output is combinational; state only changes when the top commits this window as winner.
module devil_snoop_engine_win_match
  import devil_snoop_engine_pkg::*;
#(
  parameter int ADDR_W = 44,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              glb_en_i,
  input  logic              win_en_i,
  input  logic              arm_i,
  input  logic              mode_i,
  input  logic              acflt_i,
  input  logic              addrflt_i,
  input  logic [3:0]        cfg_snoop_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] size_i,
  input  logic [ADDR_W-1:0] ac_addr_i,
  input  logic [3:0]        ac_snoop_i,
  input  logic              commit_i,
  output logic              match_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              done_o
);

  logic             armed_q, armed_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W:0]  addr_x, lo_x, hi_x;
  logic             snoop_ok, addr_ok;

  // One extra bit so base+size never wraps; size=0 yields an empty range.
  assign addr_x   = {1'b0, ac_addr_i};
  assign lo_x     = {1'b0, base_i};
  assign hi_x     = {1'b0, base_i} + {1'b0, size_i};
  assign snoop_ok = !acflt_i || (ac_snoop_i == cfg_snoop_i);
  assign addr_ok  = !addrflt_i || ((addr_x >= lo_x) && (addr_x < hi_x));
  assign match_o  = glb_en_i && win_en_i && armed_q && snoop_ok && addr_ok;

  always_comb begin
    armed_d = armed_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    if (commit_i) begin
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      if (win_mode_e'(mode_i) == WIN_OSH) begin
        armed_d = 1'b0;
        done_d  = 1'b1;
      end
    end
    // A re-arm landing on the same edge as a hit takes precedence.
    if (arm_i) begin
      armed_d = 1'b1;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      armed_q <= 1'b1;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      armed_q <= armed_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign done_o = done_q;

endmodule

// File: rtl/devil_snoop_engine.sv
// ACE snoop-channel responder with N match windows: accepts AC, answers CR after a per-window delay,
// and optionally streams a tamper line on CD. Lowest-index matching window wins.
module devil_snoop_engine
  import devil_snoop_engine_pkg::*;
#(
  parameter int N_WIN      = 4,
  parameter int ADDR_W     = 44,
  parameter int CD_W       = 128,
  parameter int LINE_BYTES = 64,
  parameter int DELAY_W    = 16,
  parameter int CNT_W      = 16
) (
  input  logic                      ace_aclk,
  input  logic                      ace_aresetn,
  input  logic                      acvalid,
  output logic                      acready,
  input  logic [ADDR_W-1:0]         acaddr,
  input  logic [3:0]                acsnoop,
  output logic                      crvalid,
  input  logic                      crready,
  output logic [4:0]                crresp,
  output logic                      cdvalid,
  input  logic                      cdready,
  output logic [CD_W-1:0]           cddata,
  output logic                      cdlast,
  input  logic                      cfg_en,
  input  logic [N_WIN-1:0]          cfg_win_en,
  input  logic [N_WIN-1:0]          cfg_win_arm,
  input  logic [N_WIN-1:0]          cfg_win_mode,
  input  logic [N_WIN-1:0]          cfg_win_acflt,
  input  logic [N_WIN-1:0]          cfg_win_addrflt,
  input  logic [N_WIN*4-1:0]        cfg_win_acsnoop,
  input  logic [N_WIN*ADDR_W-1:0]   cfg_win_base,
  input  logic [N_WIN*ADDR_W-1:0]   cfg_win_size,
  input  logic [N_WIN*DELAY_W-1:0]  cfg_win_delay,
  input  logic [N_WIN*5-1:0]        cfg_win_crresp,
  input  logic [LINE_BYTES*8-1:0]   cfg_cd_line,
  output logic [N_WIN-1:0]          sts_hit,
  output logic [N_WIN*CNT_W-1:0]    sts_hit_cnt,
  output logic [N_WIN-1:0]          sts_osh_done,
  output logic                      sts_busy
);

  localparam int CD_BEATS = LINE_BYTES * 8 / CD_W;
  localparam int BEAT_W   = (CD_BEATS > 1) ? $clog2(CD_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(CD_BEATS - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [3:0]         snoop_q, snoop_d;
  logic [DELAY_W-1:0] dly_q, dly_d;
  logic [4:0]         crresp_q, crresp_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [N_WIN-1:0]   hit_q, hit_d;

  logic [N_WIN-1:0]   win_match, win_sel, win_commit;
  logic [DELAY_W-1:0] sel_delay;
  logic [4:0]         sel_crresp;
  logic [CD_W-1:0]    cd_beat [CD_BEATS];

  // Windows only see a commit during MATCH, so counters/arm flags move once per snoop.
  assign win_commit = (state_q == ST_MATCH) ? win_sel : '0;

  generate
    for (genvar gi = 0; gi < N_WIN; gi++) begin : g_win
      devil_snoop_engine_win_match #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
      ) u_win (
        .clk         (ace_aclk),
        .rst_ni      (ace_aresetn),
        .glb_en_i    (cfg_en),
        .win_en_i    (cfg_win_en[gi]),
        .arm_i       (cfg_win_arm[gi]),
        .mode_i      (cfg_win_mode[gi]),
        .acflt_i     (cfg_win_acflt[gi]),
        .addrflt_i   (cfg_win_addrflt[gi]),
        .cfg_snoop_i (cfg_win_acsnoop[gi*4 +: 4]),
        .base_i      (cfg_win_base[gi*ADDR_W +: ADDR_W]),
        .size_i      (cfg_win_size[gi*ADDR_W +: ADDR_W]),
        .ac_addr_i   (addr_q),
        .ac_snoop_i  (snoop_q),
        .commit_i    (win_commit[gi]),
        .match_o     (win_match[gi]),
        .cnt_o       (sts_hit_cnt[gi*CNT_W +: CNT_W]),
        .done_o      (sts_osh_done[gi])
      );
    end
    for (genvar gi = 0; gi < CD_BEATS; gi++) begin : g_beat
      assign cd_beat[gi] = cfg_cd_line[gi*CD_W +: CD_W];
    end
  endgenerate

  // Walk from the top down so the lowest matching index is the last writer.
  always_comb begin
    win_sel    = '0;
    sel_delay  = '0;
    sel_crresp = '0;
    for (int i = N_WIN - 1; i >= 0; i--) begin
      if (win_match[i]) begin
        win_sel    = N_WIN'(1) << i;
        sel_delay  = cfg_win_delay[i*DELAY_W +: DELAY_W];
        sel_crresp = cfg_win_crresp[i*5 +: 5];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    snoop_d  = snoop_q;
    dly_d    = dly_q;
    crresp_d = crresp_q;
    beat_d   = beat_q;
    hit_d    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (acvalid && acready) begin
          addr_d  = acaddr;
          snoop_d = acsnoop;
          state_d = ST_MATCH;
        end
      end
      ST_MATCH: begin
        hit_d    = win_sel;
        crresp_d = sel_crresp;
        if (sel_delay == '0) begin
          state_d = ST_CR;
        end else begin
          dly_d   = sel_delay - 1'b1;
          state_d = ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (dly_q == '0) state_d = ST_CR;
        else             dly_d   = dly_q - 1'b1;
      end
      ST_CR: begin
        if (crready) begin
          if (crresp_q[CRRESP_DT]) begin
            beat_d  = '0;
            state_d = ST_CD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_CD: begin
        if (cdready) begin
          if (beat_q == LAST_BEAT) state_d = ST_IDLE;
          else                     beat_d  = beat_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ace_aclk) begin
    if (!ace_aresetn) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      snoop_q  <= '0;
      dly_q    <= '0;
      crresp_q <= '0;
      beat_q   <= '0;
      hit_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      snoop_q  <= snoop_d;
      dly_q    <= dly_d;
      crresp_q <= crresp_d;
      beat_q   <= beat_d;
      hit_q    <= hit_d;
    end
  end

  assign acready  = (state_q == ST_IDLE) && ace_aresetn;
  assign crvalid  = (state_q == ST_CR);
  assign crresp   = crvalid ? crresp_q : 5'b0;
  assign cdvalid  = (state_q == ST_CD);
  assign cdlast   = cdvalid && (beat_q == LAST_BEAT);
  assign cddata   = cdvalid ? cd_beat[beat_q] : '0;
  assign sts_hit  = hit_q;
  assign sts_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_devil_snoop_engine.sv
// Self-checking bench for devil_snoop_engine: vector table, hand-written corner sequences
// and random snoops checked against a rule-level window model.
module tb_devil_snoop_engine;

  localparam int NW = 4;
  localparam int AW = 44;
  localparam int CW = 128;
  localparam int LB = 64;
  localparam int DW = 16;
  localparam int KW = 4;
  localparam int KMAX = 15;

  logic            ace_aclk = 1'b0;
  logic            ace_aresetn = 1'b0;
  logic            acvalid = 1'b0, acready;
  logic [AW-1:0]   acaddr = '0;
  logic [3:0]      acsnoop = '0;
  logic            crvalid, crready = 1'b0;
  logic [4:0]      crresp;
  logic            cdvalid, cdready = 1'b0;
  logic [CW-1:0]   cddata;
  logic            cdlast;
  logic            g_en = 1'b1;
  logic [NW-1:0]   cfg_win_arm = '0;
  logic [NW-1:0]   w_en, w_mode, w_acflt, w_addrflt;
  logic [3:0]      w_snp  [NW];
  logic [AW-1:0]   w_base [NW];
  logic [AW-1:0]   w_size [NW];
  logic [DW-1:0]   w_dly  [NW];
  logic [4:0]      w_resp [NW];
  logic [NW*4-1:0]  cfg_win_acsnoop;
  logic [NW*AW-1:0] cfg_win_base, cfg_win_size;
  logic [NW*DW-1:0] cfg_win_delay;
  logic [NW*5-1:0]  cfg_win_crresp;
  logic [LB*8-1:0]  cd_line;
  logic [NW-1:0]    sts_hit, sts_osh_done;
  logic [NW*KW-1:0] sts_hit_cnt;
  logic             sts_busy;

  int total = 0;
  int bad = 0;
  int  m_cnt   [NW];
  bit  m_armed [NW];
  bit  m_done  [NW];

  always #5 ace_aclk = ~ace_aclk;

  always_comb begin
    cfg_win_acsnoop = '0;
    cfg_win_base    = '0;
    cfg_win_size    = '0;
    cfg_win_delay   = '0;
    cfg_win_crresp  = '0;
    for (int i = 0; i < NW; i++) begin
      cfg_win_acsnoop[i*4 +: 4] = w_snp[i];
      cfg_win_base[i*AW +: AW]  = w_base[i];
      cfg_win_size[i*AW +: AW]  = w_size[i];
      cfg_win_delay[i*DW +: DW] = w_dly[i];
      cfg_win_crresp[i*5 +: 5]  = w_resp[i];
    end
  end

  devil_snoop_engine #(
    .N_WIN(NW), .ADDR_W(AW), .CD_W(CW), .LINE_BYTES(LB), .DELAY_W(DW), .CNT_W(KW)
  ) dut (
    .ace_aclk(ace_aclk), .ace_aresetn(ace_aresetn),
    .acvalid(acvalid), .acready(acready), .acaddr(acaddr), .acsnoop(acsnoop),
    .crvalid(crvalid), .crready(crready), .crresp(crresp),
    .cdvalid(cdvalid), .cdready(cdready), .cddata(cddata), .cdlast(cdlast),
    .cfg_en(g_en), .cfg_win_en(w_en), .cfg_win_arm(cfg_win_arm), .cfg_win_mode(w_mode),
    .cfg_win_acflt(w_acflt), .cfg_win_addrflt(w_addrflt), .cfg_win_acsnoop(cfg_win_acsnoop),
    .cfg_win_base(cfg_win_base), .cfg_win_size(cfg_win_size), .cfg_win_delay(cfg_win_delay),
    .cfg_win_crresp(cfg_win_crresp), .cfg_cd_line(cd_line),
    .sts_hit(sts_hit), .sts_hit_cnt(sts_hit_cnt), .sts_osh_done(sts_osh_done), .sts_busy(sts_busy)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [3:0]    snp;
    int            hold;
    bit            tog;
    logic [4:0]    resp;
    int            lat;
  } vec_t;
  vec_t vecs [10];

  task automatic tick();
    @(posedge ace_aclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NW; i++) begin
      m_cnt[i] = 0; m_armed[i] = 1'b1; m_done[i] = 1'b0;
    end
  endtask

  // Winning window by the matching rules, or -1 when nothing matches.
  function automatic int model_win(input logic [AW-1:0] a, input logic [3:0] s);
    longint al, bl, sl;
    if (!g_en) return -1;
    al = longint'(a);
    for (int i = 0; i < NW; i++) begin
      bl = longint'(w_base[i]);
      sl = longint'(w_size[i]);
      if (w_en[i] && m_armed[i] && (!w_acflt[i] || s == w_snp[i]) &&
          (!w_addrflt[i] || (al >= bl && al < bl + sl)))
        return i;
    end
    return -1;
  endfunction

  task automatic check_model();
    for (int i = 0; i < NW; i++) begin
      chk($sformatf("hit_cnt%0d", i), sts_hit_cnt[i*KW +: KW], m_cnt[i]);
      chk($sformatf("osh_done%0d", i), sts_osh_done[i], m_done[i]);
    end
    chk("busy_idle", sts_busy, 1'b0);
  endtask

  task automatic arm_pulse(input logic [NW-1:0] m);
    cfg_win_arm = m;
    tick();
    cfg_win_arm = '0;
    for (int i = 0; i < NW; i++) if (m[i]) begin m_armed[i] = 1'b1; m_done[i] = 1'b0; end
    check_model();
  endtask

  task automatic do_snoop(input logic [AW-1:0] a, input logic [3:0] s, input int hold, input bit tog,
                          input logic [4:0] exp_resp, input int exp_lat, input logic [NW-1:0] arm_m);
    int w, lat, b, guard;
    logic [NW-1:0] exp_hit;
    w = model_win(a, s);
    exp_hit = (w >= 0) ? NW'(1 << w) : '0;
    acaddr = a; acsnoop = s; acvalid = 1'b1;
    guard = 0;
    while (!acready && guard < 20) begin tick(); guard++; end
    chk("ac_accept", acready, 1'b1);
    tick();
    acvalid = 1'b0;
    cfg_win_arm = arm_m;
    chk("busy_match", sts_busy, 1'b1);
    tick();
    cfg_win_arm = '0;
    lat = 1;
    chk("sts_hit", sts_hit, exp_hit);
    if (w >= 0) begin
      if (m_cnt[w] < KMAX) m_cnt[w]++;
      if (w_mode[w] == 1'b0) begin m_armed[w] = 1'b0; m_done[w] = 1'b1; end
    end
    for (int i = 0; i < NW; i++) if (arm_m[i]) begin m_armed[i] = 1'b1; m_done[i] = 1'b0; end
    while (!crvalid && lat < 100) begin tick(); lat++; end
    chk("cr_latency", lat, exp_lat);
    chk("crresp", crresp, exp_resp);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("cr_hold", {crvalid, crresp}, {1'b1, exp_resp});
    end
    crready = 1'b1;
    tick();
    crready = 1'b0;
    if (exp_resp[0]) begin
      b = 0; guard = 0;
      while (b < 4 && guard < 40) begin
        cdready = tog ? guard[0] : 1'b1;
        chk("cdvalid", cdvalid, 1'b1);
        chk($sformatf("cddata_b%0d", b), cddata, cd_line[b*CW +: CW]);
        chk("cdlast", cdlast, (b == 3));
        tick();
        if (cdready) b++;
        guard++;
      end
      cdready = 1'b0;
      chk("cd_beats", b, 4);
    end
    chk("b2b_acready", acready, 1'b1);
    chk("cd_idle", cdvalid, 1'b0);
    check_model();
    $display("snoop addr=%0h snp=%0d win=%0d resp=%b lat=%0d", a, s, w, exp_resp, lat);
  endtask

  initial begin
    int w;
    logic [AW-1:0] ra;
    logic [3:0] rs;
    for (int i = 0; i < LB / 4; i++) cd_line[i*32 +: 32] = $urandom;
    w_en = 4'b0111; w_mode = 4'b0101; w_acflt = 4'b0010; w_addrflt = 4'b0101;
    w_snp[0] = 4'd0; w_base[0] = 44'h0_4000_0000; w_size[0] = 44'h100;  w_dly[0] = 16'd0; w_resp[0] = 5'b00001;
    w_snp[1] = 4'd1; w_base[1] = 44'h0;           w_size[1] = 44'h0;    w_dly[1] = 16'd2; w_resp[1] = 5'b01001;
    w_snp[2] = 4'd0; w_base[2] = 44'h0_4000_0080; w_size[2] = 44'h1000; w_dly[2] = 16'd5; w_resp[2] = 5'b00100;
    w_snp[3] = 4'd0; w_base[3] = 44'h0;           w_size[3] = 44'h0;    w_dly[3] = 16'd1; w_resp[3] = 5'b00011;
    model_reset();

    vecs[0] = '{44'h0_4000_0000, 4'd0, 0, 1'b0, 5'b00001, 1};
    vecs[1] = '{44'h0_4000_00FF, 4'd0, 1, 1'b0, 5'b00001, 1};
    vecs[2] = '{44'h0_4000_0090, 4'd0, 0, 1'b0, 5'b00001, 1};
    vecs[3] = '{44'h0_4000_0100, 4'd0, 3, 1'b0, 5'b00100, 6};
    vecs[4] = '{44'h0_4000_107F, 4'd3, 0, 1'b0, 5'b00100, 6};
    vecs[5] = '{44'h0_4000_1080, 4'd2, 0, 1'b0, 5'b00000, 1};
    vecs[6] = '{44'h0_3FFF_FFFF, 4'd0, 0, 1'b0, 5'b00000, 1};
    vecs[7] = '{44'h0_0000_1234, 4'd1, 0, 1'b1, 5'b01001, 3};
    vecs[8] = '{44'h0_0000_1234, 4'd1, 0, 1'b0, 5'b00000, 1};
    vecs[9] = '{44'h0_4000_0010, 4'd1, 2, 1'b1, 5'b00001, 1};

    repeat (3) tick();
    chk("rst_acready", acready, 1'b0);
    chk("rst_valids", {crvalid, cdvalid, cdlast}, 3'b000);
    chk("rst_crresp", crresp, 5'b0);
    chk("rst_cddata", cddata, '0);
    chk("rst_sts", {sts_hit, sts_osh_done, sts_busy}, '0);
    chk("rst_cnt", sts_hit_cnt, '0);
    ace_aresetn = 1'b1;
    tick();

    for (int v = 0; v < 10; v++)
      do_snoop(vecs[v].addr, vecs[v].snp, vecs[v].hold, vecs[v].tog, vecs[v].resp, vecs[v].lat, '0);
    chk("osh_done1_set", sts_osh_done[1], 1'b1);

    arm_pulse(4'b0010);
    do_snoop(44'h0_0000_1234, 4'd1, 0, 1'b0, 5'b01001, 3, '0);
    do_snoop(44'h0_0000_1234, 4'd1, 0, 1'b0, 5'b00000, 1, '0);
    arm_pulse(4'b0010);
    do_snoop(44'h0_0000_1234, 4'd1, 0, 1'b0, 5'b01001, 3, 4'b0010);
    chk("arm_wins_done", sts_osh_done[1], 1'b0);
    do_snoop(44'h0_0000_1234, 4'd1, 0, 1'b0, 5'b01001, 3, '0);

    g_en = 1'b0;
    do_snoop(44'h0_4000_0000, 4'd1, 0, 1'b0, 5'b00000, 1, '0);
    g_en = 1'b1;

    for (int r = 0; r < 40; r++) begin
      ra = 44'h0_3FFF_FF00 + AW'($urandom_range(0, 32'h1300));
      rs = 4'($urandom_range(0, 3));
      w = model_win(ra, rs);
      do_snoop(ra, rs, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
               (w >= 0) ? w_resp[w] : 5'b0, 1 + ((w >= 0) ? int'(w_dly[w]) : 0),
               ($urandom_range(0, 3) == 0) ? 4'b0010 : 4'b0000);
    end

    // Reset in the middle of the CD burst.
    acaddr = 44'h0_4000_0000; acsnoop = 4'd0; acvalid = 1'b1;
    tick();
    acvalid = 1'b0;
    tick();
    chk("pre_rst_crvalid", crvalid, 1'b1);
    crready = 1'b1;
    tick();
    crready = 1'b0;
    cdready = 1'b1;
    tick();
    tick();
    chk("pre_rst_beat2", cddata, cd_line[2*CW +: CW]);
    ace_aresetn = 1'b0;
    tick();
    cdready = 1'b0;
    chk("mid_rst_valids", {crvalid, cdvalid, cdlast}, 3'b000);
    chk("mid_rst_busy", sts_busy, 1'b0);
    chk("mid_rst_acready", acready, 1'b0);
    chk("mid_rst_cnt", sts_hit_cnt, '0);
    chk("mid_rst_done", sts_osh_done, '0);
    ace_aresetn = 1'b1;
    model_reset();
    tick();
    chk("post_rst_acready", acready, 1'b1);

    for (int r = 0; r < 17; r++)
      do_snoop(44'h0_4000_0004, 4'd0, 0, 1'b0, 5'b00001, 1, '0);
    chk("cnt0_saturated", sts_hit_cnt[KW-1:0], 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
